// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART tx arbitration slice.
// Holds the arbiter state encoding and the round-robin pick.
package uart_pkg;

  localparam int BYTE_W  = 8;
  localparam int MAX_REQ = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    HOLD
  } state_t;

  // First set bit of mask at or above ptr, wrapping modulo n.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0] mask,
    input logic [2:0]         ptr,
    input int                 n
  );
    logic [MAX_REQ-1:0] res;
    logic [2:0]         idx;
    logic               found;
    res   = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = 3'((int'(ptr) + k) % n);
      if (k < n && !found && mask[idx]) begin
        res[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and Uart8 tx handshake bundle.
// master = arbiter side, slave = requesters plus transmitter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
) ();
  import uart_pkg::*;

  logic [NUM_REQ-1:0]        reqValid;
  logic [BYTE_W*NUM_REQ-1:0] reqData;
  logic [NUM_REQ-1:0]        reqLast;
  logic [NUM_REQ-1:0]        reqReady;

  logic              txEn;
  logic              txStart;
  logic [BYTE_W-1:0] txByte;
  logic              txBusy;
  logic              txDone;

  modport master (
    input  reqValid, reqData, reqLast,
    input  txBusy, txDone,
    output reqReady,
    output txEn, txStart, txByte
  );

  modport slave (
    output reqValid, reqData, reqLast,
    output txBusy, txDone,
    input  reqReady,
    input  txEn, txStart, txByte
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: request mask and pointer
// in, one-hot winner and its index out.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   ptr,
  output logic [N-1:0] onehot,
  output logic [2:0]   idx,
  output logic         any
);

  logic [MAX_REQ-1:0] mask;
  logic [MAX_REQ-1:0] pick;

  always_comb begin
    mask   = MAX_REQ'(req);
    pick   = rr_pick(mask, ptr, N);
    onehot = pick[N-1:0];
    idx    = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (pick[i]) idx = 3'(i);
    end
    any = |req;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one Uart8 transmitter among NUM_REQ byte streams,
// locking the grant for a whole packet.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ          = 4,
  parameter int HOLD_TIMEOUT     = 120000,
  parameter int TX_START_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  uart_tx_arbiter_if.master  bus,
  output logic [NUM_REQ-1:0] grant,
  output logic               busy,
  output logic               err
);

  localparam int HW = $clog2(HOLD_TIMEOUT) + 1;
  localparam int SW = $clog2(TX_START_TIMEOUT) + 1;
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_TIMEOUT);
  localparam logic [SW-1:0] START_MAX = SW'(TX_START_TIMEOUT);

  state_t state;

  logic [2:0]    ptr;
  logic [2:0]    owner;
  logic          last;
  logic [HW-1:0] hold_cnt;
  logic [SW-1:0] start_cnt;

  logic [NUM_REQ-1:0] pick;
  logic [2:0]         pick_idx;
  logic               pick_any;

  logic [2:0]         next_ptr;
  logic [2:0]         sel;
  logic [NUM_REQ-1:0] sel_oh;
  logic               load;
  logic               frame_end;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr (
    .req    (bus.reqValid),
    .ptr    (ptr),
    .onehot (pick),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign next_ptr = (owner == 3'(NUM_REQ - 1)) ? 3'd0
                                               : owner + 3'd1;

  // IDLE loads the fresh winner, HOLD reloads the locked owner.
  assign sel    = (state == HOLD) ? owner : pick_idx;
  assign sel_oh = (state == HOLD) ? grant : pick;
  assign load   = (state == IDLE && pick_any) ||
                  (state == HOLD && bus.reqValid[owner]);

  // A short frame may finish before busy is ever seen.
  assign frame_end = bus.txDone &&
                     (state == WAIT_BUSY || state == WAIT_DONE);

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      ptr          <= '0;
      owner        <= '0;
      last         <= 1'b0;
      hold_cnt     <= '0;
      start_cnt    <= '0;
      grant        <= '0;
      err          <= 1'b0;
      bus.reqReady <= '0;
      bus.txEn     <= 1'b0;
      bus.txStart  <= 1'b0;
      bus.txByte   <= '0;
    end else begin
      bus.reqReady <= '0;
      bus.txStart  <= 1'b0;
      if (frame_end) begin
        if (last) begin
          state    <= IDLE;
          grant    <= '0;
          bus.txEn <= 1'b0;
          ptr      <= next_ptr;
        end else begin
          state    <= HOLD;
          hold_cnt <= '0;
        end
      end else begin
        unique case (state)
          IDLE: begin
            if (pick_any) begin
              state <= LOAD;
              grant <= pick;
              owner <= pick_idx;
            end
          end
          LOAD: begin
            state       <= START;
            bus.txStart <= 1'b1;
          end
          START: begin
            state     <= WAIT_BUSY;
            start_cnt <= '0;
          end
          WAIT_BUSY: begin
            if (bus.txBusy) begin
              state <= WAIT_DONE;
            end else if (start_cnt == START_MAX) begin
              err      <= 1'b1;
              grant    <= '0;
              bus.txEn <= 1'b0;
              state    <= IDLE;
            end else begin
              start_cnt <= start_cnt + SW'(1);
            end
          end
          WAIT_DONE: begin
            state <= WAIT_DONE;
          end
          HOLD: begin
            if (load) begin
              state    <= LOAD;
              hold_cnt <= '0;
            end else if (hold_cnt == HOLD_MAX) begin
              state    <= IDLE;
              grant    <= '0;
              bus.txEn <= 1'b0;
              ptr      <= next_ptr;
            end else begin
              hold_cnt <= hold_cnt + HW'(1);
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
      if (load) begin
        bus.reqReady <= sel_oh;
        bus.txEn     <= 1'b1;
        bus.txByte   <= bus.reqData[sel*BYTE_W +: BYTE_W];
        last         <= bus.reqLast[sel];
      end
    end
  end

endmodule
